mips_cpu_load_writeback: RTL and testbench
==========================================

Name: mips_cpu_load_writeback

Overview:
- Executes one MIPS load instruction.
- Issues a word read on the Avalon-style data bus and extracts the addressed byte, halfword or word, applying sign/zero extension or the LWL/LWR merge.
- Drives the register-file write port (write_enable/write_reg/write_data) with the result.
- Sits between the execute stage (effective address, rt value) and the register file.

Parameters:
- WAIT_LIMIT, 255, max cycles spent in REQ waiting on mem_waitrequest before aborting with error; 0 = unlimited.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low
- start  input  1  one-cycle request; sampled only in IDLE
- load_type  input  3  0=LB 1=LH 2=LWL 3=LW 4=LBU 5=LHU 6=LWR 7=invalid
- address  input  32  effective byte address
- dest_reg  input  5  destination register (rt)
- rt_value  input  32  current rt contents, used by LWL/LWR
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on successful completion
- error  output  1  one-cycle pulse on misalignment, invalid type or timeout
- mem_address  output  32  word-aligned address {address[31:2],2'b00}
- mem_read  output  1  read strobe
- mem_byteenable  output  4  always 4'b1111 while mem_read=1
- mem_waitrequest  input  1  slave stall
- mem_readdata  input  32  read data, valid in the cycle mem_read=1 and mem_waitrequest=0
- write_enable  output  1  register-file write strobe
- write_reg  output  5  register-file write index
- write_data  output  32  register-file write data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0, including mem_address and write_data; captured registers cleared. Reset asserted mid-transaction aborts immediately: no write, no done, mem_read drops asynchronously.
- Interface timing: all outputs are registered; none depend combinationally on inputs.
- Lane order: little-endian; byte at offset k = address[1:0] is mem_readdata[8k+7:8k].
- IDLE:
  - On start=1, capture load_type, address, dest_reg and rt_value.
  - Error check: type 7, LH/LHU with address[0]=1, or LW with address[1:0]!=0 -> ERR. Otherwise -> REQ.
  - start while busy is ignored.
- REQ:
  - mem_read=1 and mem_address stable until a cycle with mem_waitrequest=0.
  - In that cycle capture the extracted result, then -> WB.
  - A wait counter increments on each stalled cycle; reaching WAIT_LIMIT (if nonzero) -> ERR with mem_read deasserted.
- WB:
  - write_enable=1 for exactly one cycle with write_reg and write_data. write_enable is suppressed when dest_reg=0.
  - done=1 in the same cycle; -> IDLE.
- ERR: error=1 for one cycle, no memory access (except the timeout case), no write; -> IDLE.
- Extraction (k = offset, w = readdata, r = captured rt_value):
  - LB/LBU: byte k, sign/zero extended to 32.
  - LH/LHU: half at bytes k+1..k, sign/zero extended.
  - LW: w.
  - LWL: (w << 8*(3-k)) | (r & ((1<<8*(3-k))-1)).
  - LWR: (w >> 8*k) | (r & ~(32'hFFFFFFFF >> 8*k)).
- Latency with zero wait states: start in cycle 0 -> mem_read in cycle 1 -> write_enable/done in cycle 2. Each stall cycle adds one.
- Back-to-back: a new start is accepted the cycle after done or error, since busy=0 in that cycle.

Test Plan:
- LW, address=0x100, no stall, readdata=0xDEADBEEF -> mem_address=0x100 in cycle 1; cycle 2: write_enable=1, write_reg=dest, write_data=0xDEADBEEF, done=1.
- LB, address=0x103, readdata=0x80112233 -> write_data=0xFFFFFF80. Same transaction as LBU -> 0x00000080. LHU at 0x102 with readdata=0x8001xxxx -> 0x00008001.
- LWL offset 1, rt_value=0xAABBCCDD, readdata=0x11223344 -> 0x3344CCDD. LWR offset 2, same inputs -> 0xAABB1122.
- LH at address 0x101 -> error pulse in cycle 1; mem_read never asserted; write_enable stays 0. load_type=7 gives the same response.
- mem_waitrequest high for 3 cycles -> mem_read/mem_address held 4 cycles, done in cycle 5. With WAIT_LIMIT=2 -> error, no write.
- Reset pulsed low during a REQ stall -> mem_read and busy drop immediately; no done; the next start works normally. dest_reg=0 load -> done=1, write_enable=0.

Source files
------------

// File: rtl/mips_cpu_load_writeback_if.sv
// Word-wide Avalon-style read bus between the load unit and data memory.
// The load unit is the master; the memory (or a bench model) is the slave.
interface mips_cpu_load_writeback_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  modport master (
    output mem_address,
    output mem_read,
    output mem_byteenable,
    input  mem_waitrequest,
    input  mem_readdata
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_byteenable,
    output mem_waitrequest,
    output mem_readdata
  );
endinterface

// File: rtl/mips_cpu_load_writeback.sv
// Single MIPS load: aligned word read, lane extraction / LWL-LWR merge,
// then one register-file write. All outputs come straight from flops.
module mips_cpu_load_writeback #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [2:0]                       load_type,
  input  logic [31:0]                      address,
  input  logic [4:0]                       dest_reg,
  input  logic [31:0]                      rt_value,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  mips_cpu_load_writeback_if.master        mem,
  output logic                             write_enable,
  output logic [4:0]                       write_reg,
  output logic [31:0]                      write_data
);

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LWL = 3'd2;
  localparam logic [2:0] LT_LW  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;
  localparam logic [2:0] LT_LWR = 3'd6;

  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W:0] LIMIT_V = (CNT_W + 1)'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
    logic bad;
    case (t)
      LT_LH, LT_LHU: bad = off[0];
      LT_LW:         bad = (off != 2'b00);
      LT_LB, LT_LBU, LT_LWL, LT_LWR: bad = 1'b0;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Lane select with extension, or the unaligned-word merge against rt.
  function automatic logic [31:0] extract(input logic [2:0]  t,
                                          input logic [1:0]  k,
                                          input logic [31:0] w,
                                          input logic [31:0] r);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sb;
    logic signed [31:0] sh;
    logic [4:0]         shl;
    logic [4:0]         shr;
    logic [31:0]        res;
    b   = w[{k, 3'b000} +: 8];
    h   = k[1] ? w[31:16] : w[15:0];
    sb  = 32'(b);
    sh  = 32'(h);
    shl = {~k, 3'b000};
    shr = {k, 3'b000};
    case (t)
      LT_LB:   res = sb;
      LT_LBU:  res = {24'b0, b};
      LT_LH:   res = sh;
      LT_LHU:  res = {16'b0, h};
      LT_LW:   res = w;
      LT_LWL:  res = (w << shl) | (r & ~(32'hFFFF_FFFF << shl));
      LT_LWR:  res = (w >> shr) | (r & ~(32'hFFFF_FFFF >> shr));
      default: res = '0;
    endcase
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        type_p0, type_d;
  logic [31:0]       addr_p0, addr_d;
  logic [4:0]        dest_p0, dest_d;
  logic [31:0]       rt_p0, rt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;

  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_read_q, mem_read_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              we_q, we_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [31:0]       wdata_p1, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  always_comb begin
    state_d    = state_q;
    type_d     = type_p0;
    addr_d     = addr_p0;
    dest_d     = dest_p0;
    rt_d       = rt_p0;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_read_d = 1'b0;
    mem_be_d   = 4'b0000;
    we_d       = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_p1;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      // Accept a request: capture operands and reject illegal forms up front.
      IDLE: begin
        if (start) begin
          type_d = load_type;
          addr_d = address;
          dest_d = dest_reg;
          rt_d   = rt_value;
          cnt_d  = '0;
          if (misaligned(load_type, address[1:0])) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            state_d    = REQ;
            mem_read_d = 1'b1;
            mem_be_d   = 4'b1111;
            mem_addr_d = {address[31:2], 2'b00};
          end
        end
      end

      // Bus phase: hold the read until the slave stops stalling.
      REQ: begin
        if (!mem.mem_waitrequest) begin
          state_d = WB;
          wdata_d = extract(type_p0, addr_p0[1:0], mem.mem_readdata, rt_p0);
          wreg_d  = dest_p0;
          we_d    = (dest_p0 != 5'd0);
          done_d  = 1'b1;
        end else if ((WAIT_LIMIT != 0) && (cnt_inc == LIMIT_V)) begin
          state_d = ERR;
          error_d = 1'b1;
        end else begin
          if (WAIT_LIMIT != 0) cnt_d = cnt_inc[CNT_W-1:0];
          mem_read_d = 1'b1;
          mem_be_d   = 4'b1111;
        end
      end

      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      type_p0    <= '0;
      addr_p0    <= '0;
      dest_p0    <= '0;
      rt_p0      <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      mem_be_q   <= 4'b0000;
      we_q       <= 1'b0;
      wreg_q     <= '0;
      wdata_p1   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_p0    <= type_d;
      addr_p0    <= addr_d;
      dest_p0    <= dest_d;
      rt_p0      <= rt_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      mem_be_q   <= mem_be_d;
      we_q       <= we_d;
      wreg_q     <= wreg_d;
      wdata_p1   <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign error              = error_q;
  assign mem.mem_address    = mem_addr_q;
  assign mem.mem_read       = mem_read_q;
  assign mem.mem_byteenable = mem_be_q;
  assign write_enable       = we_q;
  assign write_reg          = wreg_q;
  assign write_data         = wdata_p1;

endmodule

// File: tb/tb_mips_cpu_load_writeback.sv
// Bench for mips_cpu_load_writeback: directed loads from the test plan plus
// randomized loads with random stalls, checked cycle by cycle against a byte-level model.
module tb_mips_cpu_load_writeback;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  load_type;
  logic [31:0] address;
  logic [4:0]  dest_reg;
  logic [31:0] rt_value;
  logic        busy, done, error;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int n_checks = 0;
  int n_errors = 0;

  mips_cpu_load_writeback_if mem_if ();

  mips_cpu_load_writeback #(.WAIT_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_type    (load_type),
    .address      (address),
    .dest_reg     (dest_reg),
    .rt_value     (rt_value),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .mem          (mem_if),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_err(input int t, input logic [31:0] a);
    return (t == 7) || ((t == 1 || t == 5) && a[0]) || (t == 3 && a[1:0] != 2'b00);
  endfunction

  // Byte-level reference: memory bytes m[], register bytes rb[].
  function automatic logic [31:0] ref_load(input int t, input logic [31:0] a,
                                           input logic [31:0] r, input logic [31:0] w);
    int k;
    int v;
    logic [7:0] m  [4];
    logic [7:0] rb [4];
    logic [7:0] ob [4];
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      m[i]  = w[8*i +: 8];
      rb[i] = r[8*i +: 8];
    end
    case (t)
      0, 4: begin
        v = int'(m[k]);
        if (t == 0 && v > 127) v -= 256;
        return v;
      end
      1, 5: begin
        v = int'(m[k]) + 256 * int'(m[k+1]);
        if (t == 1 && v > 32767) v -= 65536;
        return v;
      end
      3: return w;
      2: begin
        for (int i = 0; i < 4; i++) ob[i] = (i >= 3 - k) ? m[i-(3-k)] : rb[i];
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      6: begin
        for (int i = 0; i < 4; i++) ob[i] = (i <= 3 - k) ? m[i+k] : rb[i];
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      default: return 0;
    endcase
  endfunction

  task automatic scramble_inputs();
    start     = 1'($urandom_range(0, 1));
    load_type = 3'($urandom);
    address   = $urandom;
    dest_reg  = 5'($urandom);
    rt_value  = $urandom;
  endtask

  // Issue one load in the current cycle and follow it until the unit is idle again.
  task automatic run_load(input int t, input logic [31:0] a, input logic [4:0] d,
                          input logic [31:0] r, input logic [31:0] w,
                          input int nstall, input logic [31:0] exp_data);
    bit is_err;
    bit timeout;
    int n_req;
    is_err  = ref_err(t, a);
    timeout = (nstall >= LIMIT);
    n_req   = timeout ? LIMIT : nstall + 1;

    start     = 1'b1;
    load_type = 3'(t);
    address   = a;
    dest_reg  = d;
    rt_value  = r;
    mem_if.mem_waitrequest = 1'b0;
    mem_if.mem_readdata    = $urandom;
    step();

    if (is_err) begin
      chk("err_pulse", 32'(error), 32'd1);
      chk("err_no_read", 32'(mem_if.mem_read), 32'd0);
      chk("err_busy", 32'(busy), 32'd1);
      chk("err_no_we", 32'(write_enable), 32'd0);
      chk("err_no_done", 32'(done), 32'd0);
      scramble_inputs();
      step();
    end else begin
      for (int c = 1; c <= n_req; c++) begin
        chk("req_read", 32'(mem_if.mem_read), 32'd1);
        chk("req_addr", mem_if.mem_address, {a[31:2], 2'b00});
        chk("req_be", 32'(mem_if.mem_byteenable), 32'hF);
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_idle_flags", {29'b0, done, error, write_enable}, 32'd0);
        scramble_inputs();
        mem_if.mem_waitrequest = (c <= nstall);
        mem_if.mem_readdata    = (c <= nstall) ? $urandom : w;
        step();
      end
      mem_if.mem_waitrequest = 1'b0;
      if (timeout) begin
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_no_read", 32'(mem_if.mem_read), 32'd0);
        chk("tmo_no_we", 32'(write_enable), 32'd0);
        chk("tmo_no_done", 32'(done), 32'd0);
      end else begin
        chk("wb_done", 32'(done), 32'd1);
        chk("wb_we", 32'(write_enable), 32'(d != 5'd0));
        chk("wb_reg", 32'(write_reg), 32'(d));
        if (d != 5'd0) chk("wb_data", write_data, exp_data);
        chk("wb_no_read", 32'(mem_if.mem_read), 32'd0);
        chk("wb_no_error", 32'(error), 32'd0);
      end
      scramble_inputs();
      step();
    end

    chk("end_idle", 32'(busy), 32'd0);
    chk("end_flags", {29'b0, done, error, write_enable}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    int t;
    logic [31:0] a, r, w;
    logic [4:0]  d;
    int ns;

    reset     = 1'b0;
    start     = 1'b0;
    load_type = '0;
    address   = '0;
    dest_reg  = '0;
    rt_value  = '0;
    mem_if.mem_waitrequest = 1'b0;
    mem_if.mem_readdata    = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {29'b0, done, error, write_enable}, 32'd0);
    chk("rst_read", {27'b0, mem_if.mem_read, mem_if.mem_byteenable}, 32'd0);
    chk("rst_addr", mem_if.mem_address, 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    chk("rst_wreg", 32'(write_reg), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Directed loads
    run_load(3, 32'h0000_0100, 5'd5,  32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    run_load(0, 32'h0000_0103, 5'd7,  32'h0,         32'h8011_2233, 0, 32'hFFFF_FF80);
    run_load(4, 32'h0000_0103, 5'd7,  32'h0,         32'h8011_2233, 0, 32'h0000_0080);
    run_load(5, 32'h0000_0102, 5'd8,  32'h0,         32'h8001_5566, 0, 32'h0000_8001);
    run_load(1, 32'h0000_0102, 5'd8,  32'h0,         32'h8001_5566, 0, 32'hFFFF_8001);
    run_load(2, 32'h0000_0101, 5'd9,  32'hAABB_CCDD, 32'h1122_3344, 0, 32'h3344_CCDD);
    run_load(6, 32'h0000_0102, 5'd9,  32'hAABB_CCDD, 32'h1122_3344, 0, 32'hAABB_1122);
    run_load(1, 32'h0000_0101, 5'd3,  32'h0,         32'h1234_5678, 0, 32'h0);
    run_load(7, 32'h0000_0200, 5'd3,  32'h0,         32'h1234_5678, 0, 32'h0);
    run_load(3, 32'h0000_0102, 5'd3,  32'h0,         32'h1234_5678, 0, 32'h0);
    run_load(3, 32'h0000_0400, 5'd12, 32'h0,         32'hCAFE_F00D, 3, 32'hCAFE_F00D);
    run_load(3, 32'h0000_0404, 5'd12, 32'h0,         32'hCAFE_F00D, LIMIT, 32'h0);
    run_load(3, 32'h0000_0408, 5'd0,  32'h0,         32'h5555_AAAA, 0, 32'h5555_AAAA);

    // Reset in the middle of a stalled read
    start = 1'b1; load_type = 3'd3; address = 32'h0000_0300; dest_reg = 5'd9;
    rt_value = 32'h0; mem_if.mem_waitrequest = 1'b0;
    step();
    start = 1'b0;
    mem_if.mem_waitrequest = 1'b1;
    chk("mid_read", 32'(mem_if.mem_read), 32'd1);
    step();
    chk("mid_read2", 32'(mem_if.mem_read), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_read_drop", 32'(mem_if.mem_read), 32'd0);
    chk("async_busy_drop", 32'(busy), 32'd0);
    chk("async_addr_clr", mem_if.mem_address, 32'd0);
    chk("async_flags", {29'b0, done, error, write_enable}, 32'd0);
    #1 reset = 1'b1;
    mem_if.mem_waitrequest = 1'b0;
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_flags", {29'b0, done, error, write_enable}, 32'd0);
    run_load(0, 32'h0000_0501, 5'd4, 32'h0, 32'h0000_FF00, 0, 32'hFFFF_FFFF);

    // Random loads, back-to-back, with random stalls
    for (int n = 0; n < 200; n++) begin
      t  = int'($urandom_range(0, 7));
      a  = $urandom;
      r  = $urandom;
      w  = $urandom;
      d  = 5'($urandom);
      ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LIMIT + 1)) : 0;
      run_load(t, a, d, r, w, ns, ref_err(t, a) ? 32'h0 : ref_load(t, a, r, w));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
